instruction_fetch_unit: RTL

//  Fetch stage directly upstream of the opcode decoder/datapath controller. Owns the PC,

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake and presents the word to decode.
// A one-entry skid buffer holds a word that arrives while decode is stalled.
module instruction_fetch_unit #(
    parameter int                   PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                Clk,
    input  logic                Rst,
    output logic                ImemReq,
    output logic [PC_WIDTH-1:0] ImemAddr,
    input  logic                ImemAck,
    input  logic [31:0]         ImemData,
    input  logic                Stall,
    input  logic                BranchTaken,
    input  logic [PC_WIDTH-1:0] BranchTarget,
    output logic                InstrValid,
    output logic [31:0]         Instruction,
    output logic [5:0]          OpCode,
    output logic [PC_WIDTH-1:0] PCPlus4
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    localparam logic [5:0] OPCODE_NOP = 6'b111111;

    state_t                state_reg, state_next;
    logic [PC_WIDTH-1:0]   pc_reg, pc_next;
    logic [PC_WIDTH-1:0]   drain_addr_reg, drain_addr_next;
    logic                  valid_reg, valid_next;
    logic [31:0]           instr_reg, instr_next;
    logic [5:0]            opcode_reg, opcode_next;
    logic [PC_WIDTH-1:0]   pcp4_reg, pcp4_next;
    logic                  skid_valid_reg, skid_valid_next;
    logic [31:0]           skid_instr_reg, skid_instr_next;
    logic [PC_WIDTH-1:0]   skid_pcp4_reg, skid_pcp4_next;

    logic                  req;
    logic                  can_load;
    logic [PC_WIDTH-1:0]   fetch_addr;
    logic [PC_WIDTH-1:0]   pc_plus4;

    // DRAIN keeps presenting the abandoned address until memory completes it.
    assign req        = (state_reg == FETCH) || (state_reg == DRAIN);
    assign fetch_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
    assign pc_plus4   = pc_reg + PC_WIDTH'(4);
    assign can_load   = !valid_reg || !Stall;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        valid_next      = valid_reg;
        instr_next      = instr_reg;
        opcode_next     = opcode_reg;
        pcp4_next       = pcp4_reg;
        skid_valid_next = skid_valid_reg;
        skid_instr_next = skid_instr_reg;
        skid_pcp4_next  = skid_pcp4_reg;

        if (BranchTaken) begin
            pc_next         = BranchTarget & ~PC_WIDTH'(3);
            valid_next      = 1'b0;
            skid_valid_next = 1'b0;
            opcode_next     = OPCODE_NOP;
            if (req && !ImemAck) begin
                state_next      = DRAIN;
                drain_addr_next = fetch_addr;
            end else begin
                state_next = FETCH;
            end
        end else begin
            if (can_load) begin
                if (skid_valid_reg) begin
                    valid_next      = 1'b1;
                    instr_next      = skid_instr_reg;
                    opcode_next     = skid_instr_reg[31:26];
                    pcp4_next       = skid_pcp4_reg;
                    skid_valid_next = 1'b0;
                end else if (state_reg == FETCH && ImemAck) begin
                    valid_next  = 1'b1;
                    instr_next  = ImemData;
                    opcode_next = ImemData[31:26];
                    pcp4_next   = pc_plus4;
                end else begin
                    valid_next = 1'b0;
                end
            end

            case (state_reg)
                IDLE:  state_next = FETCH;
                FETCH: begin
                    if (ImemAck) begin
                        pc_next = pc_plus4;
                        if (!can_load) begin
                            skid_valid_next = 1'b1;
                            skid_instr_next = ImemData;
                            skid_pcp4_next  = pc_plus4;
                            state_next      = HOLD;
                        end
                    end
                end
                // Output is valid in HOLD, so the skid drains exactly when Stall drops.
                HOLD:  if (!Stall) state_next = FETCH;
                DRAIN: if (ImemAck) state_next = FETCH;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
            valid_reg      <= 1'b0;
            instr_reg      <= '0;
            opcode_reg     <= OPCODE_NOP;
            pcp4_reg       <= '0;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= '0;
            skid_pcp4_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            valid_reg      <= valid_next;
            instr_reg      <= instr_next;
            opcode_reg     <= opcode_next;
            pcp4_reg       <= pcp4_next;
            skid_valid_reg <= skid_valid_next;
            skid_instr_reg <= skid_instr_next;
            skid_pcp4_reg  <= skid_pcp4_next;
        end
    end

    assign ImemReq     = req;
    assign ImemAddr    = fetch_addr;
    assign InstrValid  = valid_reg;
    assign Instruction = instr_reg;
    assign OpCode      = opcode_reg;
    assign PCPlus4     = pcp4_reg;

endmodule
